// File: rtl/np_mm_frame_scheduler.sv
// Frame scheduler for the non-pipelined matrix-multiply MAC engine: rotates NUM_BUF
// frame buffers between the loader (write side) and the engine read-address sweep.
module np_mm_frame_scheduler #(
  parameter int unsigned NUM_BUF   = 4,
  parameter int unsigned COUNT_W   = 10,
  parameter int unsigned MAX_COUNT = 783,
  parameter int unsigned PIPE_LAT  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_done,
  input  logic               halt,
  output logic [NUM_BUF-1:0] wr_sel,
  output logic               wr_ready,
  output logic [NUM_BUF-1:0] reading_frame,
  output logic [COUNT_W-1:0] buf_addr,
  output logic               mac_en,
  output logic               mac_clear,
  output logic               frame_done,
  output logic [NUM_BUF-1:0] full_flags,
  output logic               wr_overflow
);

  localparam int unsigned DW = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DONE_AT = DW'((PIPE_LAT >= 2) ? PIPE_LAT - 2 : 0);
  localparam logic [COUNT_W-1:0] LAST_ADDR = COUNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [NUM_BUF-1:0] wr_sel_q, wr_sel_d;
  logic [NUM_BUF-1:0] rd_sel_q, rd_sel_d;
  logic [NUM_BUF-1:0] full_q, full_d;
  logic [COUNT_W-1:0] addr_q, addr_d;
  logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
  logic               wr_ready_q, wr_ready_d;
  logic               mac_en_q, mac_en_d;
  logic               mac_clear_q, mac_clear_d;
  logic               frame_done_q, frame_done_d;
  logic               wr_overflow_q, wr_overflow_d;
  logic               release_buf;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rd_sel_d      = rd_sel_q;
    drain_cnt_d   = drain_cnt_q;
    mac_en_d      = 1'b0;
    mac_clear_d   = 1'b0;
    frame_done_d  = 1'b0;
    release_buf   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if ((|(rd_sel_q & full_q)) && !halt) begin
          state_d     = RUN;
          addr_d      = '0;
          mac_en_d    = 1'b1;
          mac_clear_d = 1'b1;
        end
      end
      RUN: begin
        // The presented address is consumed whenever mac_en was high, so a halt
        // only delays the next increment; the last address leaves RUN regardless.
        if (mac_en_q && (addr_q == LAST_ADDR)) begin
          state_d      = DRAIN;
          addr_d       = '0;
          release_buf  = 1'b1;
          drain_cnt_d  = '0;
          frame_done_d = (PIPE_LAT == 1);
        end else if (!halt) begin
          addr_d   = addr_q + COUNT_W'(1);
          mac_en_d = 1'b1;
        end
      end
      DRAIN: begin
        if (frame_done_q) begin
          state_d  = IDLE;
          rd_sel_d = {rd_sel_q[NUM_BUF-2:0], rd_sel_q[NUM_BUF-1]};
        end else begin
          frame_done_d = (drain_cnt_q == DONE_AT);
          drain_cnt_d  = drain_cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_sel_d      = wr_sel_q;
    full_d        = full_q;
    wr_overflow_d = wr_done && !wr_ready_q;
    if (wr_done && wr_ready_q) begin
      full_d   = full_d | wr_sel_q;
      wr_sel_d = {wr_sel_q[NUM_BUF-2:0], wr_sel_q[NUM_BUF-1]};
    end
    if (release_buf) begin
      full_d = full_d & ~rd_sel_q;
    end
    wr_ready_d = ~|(wr_sel_d & full_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_sel_q      <= NUM_BUF'(1);
      rd_sel_q      <= NUM_BUF'(1);
      full_q        <= '0;
      addr_q        <= '0;
      drain_cnt_q   <= '0;
      wr_ready_q    <= 1'b1;
      mac_en_q      <= 1'b0;
      mac_clear_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      wr_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      full_q        <= full_d;
      addr_q        <= addr_d;
      drain_cnt_q   <= drain_cnt_d;
      wr_ready_q    <= wr_ready_d;
      mac_en_q      <= mac_en_d;
      mac_clear_q   <= mac_clear_d;
      frame_done_q  <= frame_done_d;
      wr_overflow_q <= wr_overflow_d;
    end
  end

  assign wr_sel        = wr_sel_q;
  assign wr_ready      = wr_ready_q;
  assign reading_frame = rd_sel_q;
  assign buf_addr      = addr_q;
  assign mac_en        = mac_en_q;
  assign mac_clear     = mac_clear_q;
  assign frame_done    = frame_done_q;
  assign full_flags    = full_q;
  assign wr_overflow   = wr_overflow_q;

endmodule

// File: tb/tb_np_mm_frame_scheduler.sv
// Directed bench for np_mm_frame_scheduler with 2 buffers, 4-address frames, 2-cycle drain.
module tb_np_mm_frame_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_done = 1'b0;
  logic       halt = 1'b0;
  logic [1:0] wr_sel;
  logic       wr_ready;
  logic [1:0] reading_frame;
  logic [3:0] buf_addr;
  logic       mac_en;
  logic       mac_clear;
  logic       frame_done;
  logic [1:0] full_flags;
  logic       wr_overflow;

  int n_chk = 0;
  int n_bad = 0;

  np_mm_frame_scheduler #(
    .NUM_BUF  (2),
    .COUNT_W  (4),
    .MAX_COUNT(3),
    .PIPE_LAT (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_done      (wr_done),
    .halt         (halt),
    .wr_sel       (wr_sel),
    .wr_ready     (wr_ready),
    .reading_frame(reading_frame),
    .buf_addr     (buf_addr),
    .mac_en       (mac_en),
    .mac_clear    (mac_clear),
    .frame_done   (frame_done),
    .full_flags   (full_flags),
    .wr_overflow  (wr_overflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_sel"}, 32'(wr_sel), 32'h1);
    check({tag, "_rd_sel"}, 32'(reading_frame), 32'h1);
    check({tag, "_full"}, 32'(full_flags), 32'h0);
    check({tag, "_addr"}, 32'(buf_addr), 32'h0);
    check({tag, "_mac_en"}, 32'(mac_en), 32'h0);
    check({tag, "_mac_clr"}, 32'(mac_clear), 32'h0);
    check({tag, "_fdone"}, 32'(frame_done), 32'h0);
    check({tag, "_ovf"}, 32'(wr_overflow), 32'h0);
    check({tag, "_wr_rdy"}, 32'(wr_ready), 32'h1);
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_done = 1'b0; halt = 1'b0;
    step(); step();
  endtask

  initial begin
    int fd_cnt;
    int wrote;
    int done;
    int ovf;

    // 1: basic frame
    do_reset();
    check_reset_vals("rst");
    reset = 1'b0;
    wr_done = 1'b1;                         // t0
    step(); wr_done = 1'b0;                 // t1
    check("t1_full", 32'(full_flags), 32'h1);
    check("t1_wr_sel", 32'(wr_sel), 32'h2);
    check("t1_mac_en", 32'(mac_en), 32'h0);
    step();                                 // t2
    check("t2_mac_clr", 32'(mac_clear), 32'h1);
    check("t2_mac_en", 32'(mac_en), 32'h1);
    check("t2_addr", 32'(buf_addr), 32'h0);
    step();                                 // t3
    check("t3_addr", 32'(buf_addr), 32'h1);
    check("t3_mac_clr", 32'(mac_clear), 32'h0);
    step();                                 // t4
    check("t4_addr", 32'(buf_addr), 32'h2);
    step();                                 // t5
    check("t5_addr", 32'(buf_addr), 32'h3);
    check("t5_mac_en", 32'(mac_en), 32'h1);
    step();                                 // t6
    check("t6_mac_en", 32'(mac_en), 32'h0);
    check("t6_fdone", 32'(frame_done), 32'h0);
    check("t6_full", 32'(full_flags), 32'h0);
    check("t6_addr", 32'(buf_addr), 32'h0);
    step();                                 // t7
    check("t7_fdone", 32'(frame_done), 32'h1);
    check("t7_rd_sel", 32'(reading_frame), 32'h1);
    step();                                 // t8
    check("t8_fdone", 32'(frame_done), 32'h0);
    check("t8_rd_sel", 32'(reading_frame), 32'h2);
    check("t8_mac_en", 32'(mac_en), 32'h0);

    // 2: fill both buffers, then overflow
    do_reset(); reset = 1'b0;
    wr_done = 1'b1;                         // t0
    step();                                 // t1
    check("ov_t1_wr_rdy", 32'(wr_ready), 32'h1);
    step();                                 // t2, wr_done still high
    check("ov_t2_full", 32'(full_flags), 32'h3);
    check("ov_t2_wr_rdy", 32'(wr_ready), 32'h0);
    check("ov_t2_wr_sel", 32'(wr_sel), 32'h1);
    step(); wr_done = 1'b0;                 // t3
    check("ov_t3_ovf", 32'(wr_overflow), 32'h1);
    check("ov_t3_full", 32'(full_flags), 32'h3);
    check("ov_t3_wr_sel", 32'(wr_sel), 32'h1);
    step();                                 // t4
    check("ov_t4_ovf", 32'(wr_overflow), 32'h0);

    // 3: halt while addr=1
    do_reset(); reset = 1'b0;
    wr_done = 1'b1;                         // t0
    step(); wr_done = 1'b0;                 // t1
    step();                                 // t2
    step();                                 // t3
    check("h_t3_addr", 32'(buf_addr), 32'h1);
    halt = 1'b1;
    step();                                 // t4
    check("h_t4_addr", 32'(buf_addr), 32'h1);
    check("h_t4_mac_en", 32'(mac_en), 32'h0);
    step(); halt = 1'b0;                    // t5
    check("h_t5_addr", 32'(buf_addr), 32'h1);
    check("h_t5_mac_en", 32'(mac_en), 32'h0);
    step();                                 // t6
    check("h_t6_addr", 32'(buf_addr), 32'h2);
    check("h_t6_mac_en", 32'(mac_en), 32'h1);
    step();                                 // t7
    check("h_t7_addr", 32'(buf_addr), 32'h3);
    step();                                 // t8
    check("h_t8_fdone", 32'(frame_done), 32'h0);
    check("h_t8_mac_en", 32'(mac_en), 32'h0);
    step();                                 // t9
    check("h_t9_fdone", 32'(frame_done), 32'h1);
    step();                                 // t10
    check("h_t10_rd_sel", 32'(reading_frame), 32'h2);

    // 4: release buffer 0 while buffer 1 is filled
    do_reset(); reset = 1'b0;
    wr_done = 1'b1;                         // t0
    step(); wr_done = 1'b0;                 // t1
    step(); step(); step();                 // t4
    step();                                 // t5
    check("s_t5_addr", 32'(buf_addr), 32'h3);
    check("s_t5_wr_rdy", 32'(wr_ready), 32'h1);
    wr_done = 1'b1;
    step(); wr_done = 1'b0;                 // t6
    check("s_t6_full", 32'(full_flags), 32'h2);
    check("s_t6_wr_sel", 32'(wr_sel), 32'h1);
    check("s_t6_wr_rdy", 32'(wr_ready), 32'h1);
    step(); step();                         // t8
    check("s_t8_rd_sel", 32'(reading_frame), 32'h2);
    step();                                 // t9
    check("s_t9_mac_clr", 32'(mac_clear), 32'h1);
    check("s_t9_addr", 32'(buf_addr), 32'h0);

    // 5: reset mid-frame
    do_reset(); reset = 1'b0;
    wr_done = 1'b1;                         // t0
    step(); wr_done = 1'b0;                 // t1
    step(); step(); step();                 // t4
    check("r_t4_addr", 32'(buf_addr), 32'h2);
    reset = 1'b1;
    step();                                 // t5
    check_reset_vals("r_t5");
    reset = 1'b0;
    fd_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      fd_cnt += int'(frame_done) + int'(mac_en);
    end
    check("r_no_activity", 32'(fd_cnt), 32'h0);

    // 6: stream 8 frames
    do_reset(); reset = 1'b0;
    wrote = 0; done = 0; ovf = 0;
    for (int c = 0; c < 150 && done < 8; c++) begin
      wr_done = wr_ready && (wrote < 8);
      if (wr_done) wrote++;
      if (frame_done) begin
        check("st_rd_sel", 32'(reading_frame), (done % 2 == 1) ? 32'h2 : 32'h1);
        done++;
      end
      ovf += int'(wr_overflow);
      step();
    end
    wr_done = 1'b0;
    check("st_done_cnt", 32'(done), 32'd8);
    check("st_ovf_cnt", 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
